// File: rtl/wbi_sched_pkg.sv
// Shared types and helpers for the Wishbone response-return scheduler.
package wbi_sched_pkg;

    typedef enum logic {
        SCH_IDLE = 1'b0,
        SCH_BUSY = 1'b1
    } sch_state_e;

    localparam int NR_MAX = 8;

    // Index of the set bit of a one-hot vector (0 when the vector is empty).
    function automatic logic [2:0] onehot2idx(input logic [NR_MAX-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NR_MAX; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wbi_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping at NR-1.
module wbi_rr_pick #(
    parameter int NR = 4,
    localparam int PW = (NR > 1) ? $clog2(NR) : 1
) (
    input  logic [NR-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [NR-1:0] gnt,
    output logic          any
);

    logic [PW-1:0] w_idx;

    // Walk the requesters starting at ptr and keep the first one found.
    always_comb begin
        gnt   = '0;
        any   = 1'b0;
        w_idx = '0;
        for (int i = 0; i < NR; i++) begin
            w_idx = PW'((int'(ptr) + i) % NR);
            if (!any && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wbi_res_sched.sv
// Burst-aware round-robin scheduler for the shared response return path.
// A winning source owns the master port until its last beat, or until the
// lock-timeout watchdog sees it idle for LTO granted cycles.
module wbi_res_sched
    import wbi_sched_pkg::*;
#(
    parameter int NR  = 4,
    parameter int DW  = 32,
    parameter int LTO = 255
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic [NR-1:0]    src_rval_i,
    input  logic [NR*DW-1:0] src_dat_i,
    input  logic [NR-1:0]    src_ack_i,
    input  logic [NR-1:0]    src_lack_i,
    input  logic [NR-1:0]    src_err_i,
    input  logic [NR*4-1:0]  src_tid_i,
    output logic [NR-1:0]    src_rrdy_o,
    input  logic             wbp_res_rrdy_i,
    output logic             wbp_res_rval_o,
    output logic [DW-1:0]    wbp_res_dat_o,
    output logic             wbp_res_ack_o,
    output logic             wbp_res_lack_o,
    output logic             wbp_res_err_o,
    output logic [3:0]       wbp_res_tid_o,
    output logic [NR-1:0]    gnt_o,
    output logic             lock_o,
    output logic             lto_o
);

    localparam int PW = (NR > 1) ? $clog2(NR) : 1;
    localparam int CW = (LTO > 1) ? $clog2(LTO) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((LTO > 0) ? LTO - 1 : 0);

    sch_state_e    r_state, w_state_nxt;
    logic [NR-1:0] r_gnt, w_gnt_nxt;
    logic [PW-1:0] r_ptr, w_ptr_nxt;
    logic          r_lock, w_lock_nxt;
    logic          r_lto;
    logic [CW-1:0] r_wdc, w_wdc_nxt;

    logic          w_busy, w_hs, w_expire, w_any;
    logic [PW-1:0] w_gidx, w_gnxt, w_pick_ptr;
    logic [NR-1:0] w_pick;
    logic          w_rval_g, w_ack_g, w_lack_g, w_err_g;
    logic [DW-1:0] w_dat_g;
    logic [3:0]    w_tid_g;

    assign w_busy     = (r_state == SCH_BUSY);
    assign w_gidx     = PW'(onehot2idx(NR_MAX'(r_gnt)));
    assign w_gnxt     = (w_gidx == PW'(NR - 1)) ? '0 : w_gidx + 1'b1;
    // After a last beat the finished source drops to lowest priority.
    assign w_pick_ptr = w_busy ? w_gnxt : r_ptr;

    wbi_rr_pick #(.NR(NR)) u_pick (
        .req (src_rval_i),
        .ptr (w_pick_ptr),
        .gnt (w_pick),
        .any (w_any)
    );

    // Response mux; an empty grant leaves every field at zero.
    always_comb begin
        w_rval_g = 1'b0;
        w_ack_g  = 1'b0;
        w_lack_g = 1'b0;
        w_err_g  = 1'b0;
        w_dat_g  = '0;
        w_tid_g  = '0;
        for (int k = 0; k < NR; k++) begin
            if (r_gnt[k]) begin
                w_rval_g = src_rval_i[k];
                w_ack_g  = src_ack_i[k];
                w_lack_g = src_lack_i[k];
                w_err_g  = src_err_i[k];
                w_dat_g  = src_dat_i[k*DW +: DW];
                w_tid_g  = src_tid_i[k*4 +: 4];
            end
        end
    end

    assign w_hs     = w_busy && w_rval_g && wbp_res_rrdy_i;
    assign w_expire = (LTO != 0) && w_busy && !w_rval_g && (r_wdc == WD_LAST);

    // Next-state logic: grant changes only on a last-beat handshake or watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock;
        w_wdc_nxt   = r_wdc;
        case (r_state)
            SCH_IDLE: begin
                w_wdc_nxt = '0;
                if (w_any) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = SCH_BUSY;
                end
            end
            SCH_BUSY: begin
                if (w_hs) begin
                    w_wdc_nxt = '0;
                    if (w_lack_g) begin
                        w_lock_nxt = 1'b0;
                        w_ptr_nxt  = w_gnxt;
                        w_gnt_nxt  = w_pick;
                        if (!w_any) w_state_nxt = SCH_IDLE;
                    end else begin
                        w_lock_nxt = 1'b1;
                    end
                end else if (w_rval_g) begin
                    w_wdc_nxt = '0;
                end else if (w_expire) begin
                    w_wdc_nxt   = '0;
                    w_gnt_nxt   = '0;
                    w_lock_nxt  = 1'b0;
                    w_ptr_nxt   = w_gnxt;
                    w_state_nxt = SCH_IDLE;
                end else if (LTO != 0) begin
                    w_wdc_nxt = r_wdc + 1'b1;
                end
            end
        endcase
    end

    // Control registers; the lto pulse is the registered expiry strobe.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_state <= SCH_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_lock  <= 1'b0;
            r_lto   <= 1'b0;
            r_wdc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_lock  <= w_lock_nxt;
            r_lto   <= w_expire;
            r_wdc   <= w_wdc_nxt;
        end
    end

    assign src_rrdy_o     = r_gnt & {NR{wbp_res_rrdy_i}};
    assign wbp_res_rval_o = w_rval_g;
    assign wbp_res_dat_o  = w_dat_g;
    assign wbp_res_ack_o  = w_ack_g;
    assign wbp_res_lack_o = w_lack_g;
    assign wbp_res_err_o  = w_err_g;
    assign wbp_res_tid_o  = w_tid_g;
    assign gnt_o          = r_gnt;
    assign lock_o         = r_lock;
    assign lto_o          = r_lto;

    // A granted source must hold rval until its beat is taken.
    a_hold_rval: assert property (@(posedge mclk) disable iff (reset)
        (w_busy && w_rval_g && !wbp_res_rrdy_i) |=> w_rval_g);

endmodule

// File: tb/tb_wbi_res_sched.sv
// Testbench for wbi_res_sched: directed tables/sequences plus random traffic
// checked against a queue-based behavioural model.
module tb_wbi_res_sched;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int LTO = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [NR-1:0]  rval, ack, lack, err;
    logic [NR*DW-1:0] dat;
    logic [NR*4-1:0]  tid;
    logic           rrdy;
    logic [NR-1:0]  src_rrdy, gnt;
    logic           o_rval, o_ack, o_lack, o_err, lock, lto;
    logic [DW-1:0]  o_dat;
    logic [3:0]     o_tid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wbi_res_sched #(.NR(NR), .DW(DW), .LTO(LTO)) dut (
        .mclk           (clk),
        .reset          (reset),
        .src_rval_i     (rval),
        .src_dat_i      (dat),
        .src_ack_i      (ack),
        .src_lack_i     (lack),
        .src_err_i      (err),
        .src_tid_i      (tid),
        .src_rrdy_o     (src_rrdy),
        .wbp_res_rrdy_i (rrdy),
        .wbp_res_rval_o (o_rval),
        .wbp_res_dat_o  (o_dat),
        .wbp_res_ack_o  (o_ack),
        .wbp_res_lack_o (o_lack),
        .wbp_res_err_o  (o_err),
        .wbp_res_tid_o  (o_tid),
        .gnt_o          (gnt),
        .lock_o         (lock),
        .lto_o          (lto)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        lk;
        logic        e;
        logic [3:0]  t;
    } beat_t;

    typedef struct {
        logic        rrdy;
        logic [3:0]  exp_gnt;
        logic [3:0]  exp_srdy;
        logic        exp_rval;
        logic [3:0]  exp_tid;
        logic [31:0] exp_dat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_src(input int k, input logic v, input logic [31:0] d,
                           input logic lk, input logic [3:0] t);
        rval[k] = v;
        ack[k]  = v;
        lack[k] = lk;
        err[k]  = 1'b0;
        dat[k*DW +: DW] = d;
        tid[k*4 +: 4]   = t;
    endtask

    task automatic clr_all();
        rval = '0; ack = '0; lack = '0; err = '0; dat = '0; tid = '0;
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_all();
        reset = 1'b1;
        to_next();
        to_next();
        reset = 1'b0;
    endtask

    // Behavioural model state for the random phase
    beat_t q [NR][$];
    int    own, ptr, wcnt;
    logic  m_lock, m_lto;

    function automatic int pick(input logic [NR-1:0] rv, input int p);
        for (int i = 0; i < NR; i++)
            if (rv[(p + i) % NR]) return (p + i) % NR;
        return -1;
    endfunction

    vec_t t2 [5];
    vec_t t4 [7];

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1: reset with every source requesting
        clr_all();
        rrdy  = 1'b1;
        reset = 1'b1;
        for (int k = 0; k < NR; k++) set_src(k, 1'b1, 32'h1000 + k, 1'b1, 4'(k + 1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_gnt", gnt, 0);
            check("rst_rval", o_rval, 0);
            check("rst_srdy", src_rrdy, 0);
        end
        to_next();
        reset = 1'b0;
        @(negedge clk);
        check("arb_cycle_gnt", gnt, 0);
        check("arb_cycle_rval", o_rval, 0);

        // Test 2: round robin over continuous single beats
        t2[0] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 4'd1, 32'h1000};
        t2[1] = '{1'b1, 4'b0010, 4'b0010, 1'b1, 4'd2, 32'h1001};
        t2[2] = '{1'b1, 4'b0100, 4'b0100, 1'b1, 4'd3, 32'h1002};
        t2[3] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 4'd4, 32'h1003};
        t2[4] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 4'd1, 32'h1000};
        for (int r = 0; r < 5; r++) begin
            rrdy = t2[r].rrdy;
            @(negedge clk);
            check("rr_gnt", gnt, t2[r].exp_gnt);
            check("rr_srdy", src_rrdy, t2[r].exp_srdy);
            check("rr_rval", o_rval, t2[r].exp_rval);
            check("rr_tid", o_tid, t2[r].exp_tid);
            check("rr_dat", o_dat, t2[r].exp_dat);
        end
        to_next();

        // Test 3: 4-beat burst from src1 is not interleaved
        do_reset();
        set_src(0, 1'b1, 32'hA0, 1'b1, 4'hA);
        set_src(1, 1'b1, 32'd100, 1'b0, 4'h5);
        set_src(2, 1'b1, 32'hC0, 1'b1, 4'hC);
        rrdy = 1'b1;
        @(negedge clk);
        check("b_idle_gnt", gnt, 0);
        to_next();
        @(negedge clk);
        check("b_src0_gnt", gnt, 4'b0001);
        check("b_src0_tid", o_tid, 4'hA);
        to_next();
        set_src(0, 1'b0, 32'h0, 1'b0, 4'h0);
        for (int b = 0; b < 4; b++) begin
            set_src(1, 1'b1, 32'd100 + 32'(b), (b == 3), 4'h5);
            @(negedge clk);
            check("b_gnt", gnt, 4'b0010);
            check("b_tid", o_tid, 4'h5);
            check("b_dat", o_dat, 32'd100 + 32'(b));
            check("b_lock", lock, (b > 0));
            to_next();
        end
        set_src(1, 1'b0, 32'h0, 1'b0, 4'h0);
        @(negedge clk);
        check("b_next_gnt", gnt, 4'b0100);
        check("b_next_tid", o_tid, 4'hC);
        check("b_next_lock", lock, 0);
        to_next();

        // Test 4: backpressure during a src3 burst
        do_reset();
        t4[0] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0, 32'h0};
        t4[1] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 4'd3, 32'hD0};
        t4[2] = '{1'b0, 4'b1000, 4'b0000, 1'b1, 4'd3, 32'hD1};
        t4[3] = '{1'b0, 4'b1000, 4'b0000, 1'b1, 4'd3, 32'hD1};
        t4[4] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 4'd3, 32'hD1};
        t4[5] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 4'd3, 32'hD2};
        t4[6] = '{1'b1, 4'b1000, 4'b1000, 1'b0, 4'd0, 32'h0};
        begin
            int idx;
            idx = 0;
            for (int r = 0; r < 7; r++) begin
                rrdy = t4[r].rrdy;
                if (idx < 3) set_src(3, 1'b1, 32'hD0 + 32'(idx), (idx == 2), 4'd3);
                else         set_src(3, 1'b0, 32'h0, 1'b0, 4'h0);
                @(negedge clk);
                check("bp_gnt", gnt, t4[r].exp_gnt);
                check("bp_srdy", src_rrdy, t4[r].exp_srdy);
                check("bp_rval", o_rval, t4[r].exp_rval);
                check("bp_tid", o_tid, t4[r].exp_tid);
                check("bp_dat", o_dat, t4[r].exp_dat);
                if (t4[r].rrdy && t4[r].exp_gnt != 0 && idx < 3) idx++;
                to_next();
            end
        end

        // Test 5: watchdog releases a stalled src0 lock
        do_reset();
        rrdy = 1'b1;
        set_src(0, 1'b1, 32'h55, 1'b0, 4'h1);
        set_src(2, 1'b1, 32'h77, 1'b1, 4'h2);
        @(negedge clk);
        check("wd_idle_gnt", gnt, 0);
        to_next();
        @(negedge clk);
        check("wd_src0_gnt", gnt, 4'b0001);
        to_next();
        set_src(0, 1'b0, 32'h0, 1'b0, 4'h0);
        for (int c = 0; c < LTO; c++) begin
            @(negedge clk);
            check("wd_wait_lto", lto, 0);
            check("wd_wait_gnt", gnt, 4'b0001);
            check("wd_wait_lock", lock, 1);
            to_next();
        end
        @(negedge clk);
        check("wd_pulse_lto", lto, 1);
        check("wd_pulse_gnt", gnt, 0);
        check("wd_pulse_lock", lock, 0);
        to_next();
        @(negedge clk);
        check("wd_after_gnt", gnt, 4'b0100);
        check("wd_after_lto", lto, 0);
        to_next();

        // Test 6: reset in the middle of a src2 burst
        do_reset();
        rrdy = 1'b1;
        set_src(2, 1'b1, 32'h60, 1'b0, 4'h6);
        @(negedge clk);
        check("mr_idle_gnt", gnt, 0);
        to_next();
        @(negedge clk);
        check("mr_b0_gnt", gnt, 4'b0100);
        to_next();
        set_src(2, 1'b1, 32'h61, 1'b0, 4'h6);
        set_src(0, 1'b1, 32'h90, 1'b1, 4'h9);
        reset = 1'b1;
        @(negedge clk);
        check("mr_b1_gnt", gnt, 4'b0100);
        check("mr_b1_lock", lock, 1);
        to_next();
        @(negedge clk);
        check("mr_rst_gnt", gnt, 0);
        check("mr_rst_lock", lock, 0);
        check("mr_rst_rval", o_rval, 0);
        check("mr_rst_srdy", src_rrdy, 0);
        check("mr_rst_lto", lto, 0);
        to_next();
        reset = 1'b0;
        @(negedge clk);
        check("mr_rel_gnt", gnt, 0);
        to_next();
        @(negedge clk);
        check("mr_first_gnt", gnt, 4'b0001);
        check("mr_first_tid", o_tid, 4'h9);
        to_next();

        // Random traffic against the behavioural model
        do_reset();
        for (int k = 0; k < NR; k++) q[k].delete();
        own = -1; ptr = 0; wcnt = 0; m_lock = 1'b0; m_lto = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [NR-1:0] rv;
            logic [3:0]    e_gnt, e_srdy;
            logic [39:0]   e_res;
            logic          lto_n;
            beat_t         hb;
            // new bursts arrive, then present queue heads
            for (int k = 0; k < NR; k++) begin
                if (q[k].size() < 6 && $urandom_range(0, 9) == 0) begin
                    int len;
                    logic [3:0] t;
                    len = $urandom_range(1, 4);
                    t   = 4'($urandom_range(0, 15));
                    for (int b = 0; b < len; b++) begin
                        beat_t nb;
                        nb.d  = $urandom;
                        nb.lk = (b == len - 1);
                        nb.e  = ($urandom_range(0, 7) == 0);
                        nb.t  = t;
                        q[k].push_back(nb);
                    end
                end
                if (q[k].size() > 0) begin
                    hb = q[k][0];
                    set_src(k, 1'b1, hb.d, hb.lk, hb.t);
                    err[k] = hb.e;
                end else begin
                    set_src(k, 1'b0, 32'h0, 1'b0, 4'h0);
                end
            end
            rrdy = ($urandom_range(0, 3) != 0);
            rv = rval;

            // expected outputs from the model state
            e_gnt  = (own < 0) ? 4'b0 : 4'(1 << own);
            e_srdy = rrdy ? e_gnt : 4'b0;
            e_res  = '0;
            if (own >= 0 && rv[own]) begin
                hb = q[own][0];
                e_res = {1'b1, 1'b1, hb.lk, hb.e, hb.t, hb.d};
            end
            @(negedge clk);
            check("rnd_gnt", gnt, e_gnt);
            check("rnd_srdy", src_rrdy, e_srdy);
            check("rnd_lock", lock, m_lock);
            check("rnd_lto", lto, m_lto);
            check("rnd_res", {o_rval, o_ack, o_lack, o_err, o_tid, o_dat}, e_res);

            // advance the model by one cycle
            lto_n = 1'b0;
            if (own < 0) begin
                own  = pick(rv, ptr);
                wcnt = 0;
            end else if (rv[own] && rrdy) begin
                hb   = q[own].pop_front();
                wcnt = 0;
                if (hb.lk) begin
                    m_lock = 1'b0;
                    ptr    = (own + 1) % NR;
                    own    = pick(rv, ptr);
                end else begin
                    m_lock = 1'b1;
                end
            end else if (rv[own]) begin
                wcnt = 0;
            end else if (wcnt == LTO - 1) begin
                lto_n  = 1'b1;
                m_lock = 1'b0;
                ptr    = (own + 1) % NR;
                own    = -1;
                wcnt   = 0;
            end else begin
                wcnt++;
            end
            m_lto = lto_n;
            to_next();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
